// File: rtl/imm_gen_pkg.sv
// Shared types for the decode-stage immediate generator: format codes,
// base opcodes and the XLEN legality check.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_SHAMT = 3'd2,
        FMT_S     = 3'd3,
        FMT_B     = 3'd4,
        FMT_U     = 3'd5,
        FMT_J     = 3'd6,
        FMT_ZIMM  = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    function automatic bit xlen_ok(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_gen_slice.sv
// One valid/ready register slice; payload width set by W.
// Flush drops the held entry; data only moves on an accepted handshake.
module imm_gen_slice
    import imm_gen_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    assign up_ready = !dn_valid || dn_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (flush) begin
            dn_valid <= 1'b0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) dn_data <= up_data;
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator with PIPE_STAGES valid/ready slices.
// Define IMM_GEN_CSR_ZIMM_EN to decode CSR*I zimm as fmt ZIMM.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PIPE_STAGES = 1,
    parameter int TAG_W       = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output fmt_e             out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PW = XLEN + 4 + TAG_W;

    if (!xlen_ok(XLEN) || PIPE_STAGES < 1 || PIPE_STAGES > 2) begin : g_bad_cfg
        $error("imm_gen_pipe: unsupported XLEN or PIPE_STAGES");
    end

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic            sh;
    fmt_e            fmt;
    logic            illegal;
    logic [31:0]     imm32;
    logic            sext;
    logic [XLEN-1:0] imm;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign sh  = (f3 == 3'b001) || (f3 == 3'b101);

    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b0;
        unique case (opc)
            OPC_OP_IMM:          fmt = sh ? FMT_SHAMT : FMT_I;
            OPC_LOAD, OPC_JALR:  fmt = FMT_I;
            OPC_STORE:           fmt = FMT_S;
            OPC_BRANCH:          fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:  fmt = FMT_U;
            OPC_JAL:             fmt = FMT_J;
            OPC_OP:              fmt = FMT_NONE;
            OPC_SYSTEM: begin
`ifdef IMM_GEN_CSR_ZIMM_EN
                fmt = f3[2] ? FMT_ZIMM : FMT_NONE;
`else
                fmt = FMT_NONE;
`endif
            end
            OPC_OP_IMM32: begin
                if (XLEN == 64) fmt = sh ? FMT_SHAMT : FMT_I;
                else            illegal = 1'b1;
            end
            default:             illegal = 1'b1;
        endcase
    end

    // Build a 32-bit field, then sign- or zero-extend once to XLEN
    always_comb begin
        imm32 = '0;
        sext  = 1'b1;
        unique case (fmt)
            FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_SHAMT: begin
                sext = 1'b0;
                if (XLEN == 64 && opc == OPC_OP_IMM)
                    imm32 = {26'b0, in_instr[25:20]};
                else
                    imm32 = {27'b0, in_instr[24:20]};
            end
            FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25],
                            in_instr[11:7]};
            FMT_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U: imm32 = {in_instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{in_instr[31]}}, in_instr[31],
                            in_instr[19:12], in_instr[20],
                            in_instr[30:21], 1'b0};
            FMT_ZIMM: begin
                sext  = 1'b0;
                imm32 = {27'b0, in_instr[19:15]};
            end
            default: imm32 = '0;
        endcase
    end

    assign imm = sext ? XLEN'($signed(imm32)) : XLEN'(imm32);

    logic [PIPE_STAGES:0] v;
    logic [PIPE_STAGES:0] r;
    logic [PW-1:0]        d [PIPE_STAGES+1];
    logic [2:0]           fmt_bits;

    assign v[0]           = in_valid;
    assign d[0]           = {imm, fmt, illegal, in_tag};
    assign r[PIPE_STAGES] = out_ready;
    assign in_ready       = r[0];

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        imm_gen_slice #(.W(PW)) u_slice (
            .clk      (clk),
            .rstn     (rstn),
            .flush    (flush),
            .up_valid (v[k]),
            .up_ready (r[k]),
            .up_data  (d[k]),
            .dn_valid (v[k+1]),
            .dn_ready (r[k+1]),
            .dn_data  (d[k+1])
        );
    end

    assign out_valid = v[PIPE_STAGES];
    assign {out_imm, fmt_bits, out_illegal, out_tag} = d[PIPE_STAGES];
    assign out_fmt = fmt_e'(fmt_bits);

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed steps plus random traffic checked
// against an arithmetic reference model and an in-order scoreboard.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    localparam int XLEN = 32;
    localparam int P    = 2;
    localparam int TW   = 32;

    logic            clk = 1'b0;
    logic            rstn;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [TW-1:0]   in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    fmt_e            out_fmt;
    logic            out_illegal;
    logic [TW-1:0]   out_tag;

    imm_gen_pipe #(.XLEN(XLEN), .PIPE_STAGES(P), .TAG_W(TW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_illegal (out_illegal),
        .out_tag     (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    logic acc;
    logic stall_pending = 1'b0;
    exp_t held;

    localparam logic [6:0] OPS [14] = '{
        7'h13, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
        7'h17, 7'h6F, 7'h33, 7'h73, 7'h1B, 7'h7F, 7'h00
    };

    task automatic chk(input string nm, input logic [63:0] obs,
                       input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, expv);
        end
    endtask

    // Reference decode written from the ISA field rules with arithmetic
    function automatic exp_t ref_model(input logic [31:0] ins,
                                       input logic [31:0] tg);
        exp_t e;
        int   op;
        int   f3;
        int   val;
        logic signed [31:0] sx;
        op  = int'(ins & 32'h7F);
        f3  = int'((ins >> 12) & 32'h7);
        sx  = $signed(ins);
        val = 0;
        e.ill = 1'b0;
        e.tag = tg;
        e.fmt = FMT_NONE;
        if (op == 'h13) e.fmt = (f3 == 1 || f3 == 5) ? FMT_SHAMT : FMT_I;
        else if (op == 'h03 || op == 'h67) e.fmt = FMT_I;
        else if (op == 'h23) e.fmt = FMT_S;
        else if (op == 'h63) e.fmt = FMT_B;
        else if (op == 'h37 || op == 'h17) e.fmt = FMT_U;
        else if (op == 'h6F) e.fmt = FMT_J;
        else if (op == 'h33) e.fmt = FMT_NONE;
        else if (op == 'h73) begin
`ifdef IMM_GEN_CSR_ZIMM_EN
            if (f3 >= 4) e.fmt = FMT_ZIMM;
`endif
        end else e.ill = 1'b1;
        case (e.fmt)
            FMT_I:     val = int'(sx >>> 20);
            FMT_SHAMT: val = int'((ins >> 20) & 32'h1F);
            FMT_S:     val = (int'(sx >>> 25) * 32) + int'((ins >> 7) & 32'h1F);
            FMT_B:     val = (ins[31] ? -4096 : 0)
                           + int'((ins >> 7) & 32'h1) * 2048
                           + int'((ins >> 25) & 32'h3F) * 32
                           + int'((ins >> 8) & 32'hF) * 2;
            FMT_U:     val = int'(ins & 32'hFFFFF000);
            FMT_J:     val = (ins[31] ? -(1 << 20) : 0)
                           + int'((ins >> 12) & 32'hFF) * 4096
                           + int'((ins >> 20) & 32'h1) * 2048
                           + int'((ins >> 21) & 32'h3FF) * 2;
            FMT_ZIMM:  val = int'((ins >> 15) & 32'h1F);
            default:   val = 0;
        endcase
        e.imm = 32'(val);
        return e;
    endfunction

    // One clock: drive at negedge, sample just after, then cross posedge
    task automatic step(input logic v, input logic [31:0] ins,
                        input logic ordy, input logic fl);
        exp_t e;
        exp_t cur;
        logic take;
        in_valid  = v;
        in_instr  = ins;
        in_tag    = $urandom;
        out_ready = ordy;
        flush     = fl;
        #1;
        cur  = {out_imm, out_fmt, out_illegal, out_tag};
        acc  = in_valid && in_ready && !fl;
        take = out_valid && out_ready;
        if (stall_pending) chk("hold_stable", 64'(cur), 64'(held));
        if (take) begin
            if (q.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = q.pop_front();
                chk("sb_imm", 64'(out_imm), 64'(e.imm));
                chk("sb_fmt", 64'(out_fmt), 64'(e.fmt));
                chk("sb_ill", 64'(out_illegal), 64'(e.ill));
                chk("sb_tag", 64'(out_tag), 64'(e.tag));
            end
        end
        if (acc) q.push_back(ref_model(in_instr, in_tag));
        stall_pending = out_valid && !out_ready && !fl;
        held = cur;
        @(posedge clk);
        if (fl) q.delete();
        @(negedge clk);
    endtask

    task automatic one(input string nm, input logic [31:0] ins,
                       input logic [31:0] ei, input fmt_e ef,
                       input logic eill);
        step(1'b1, ins, 1'b1, 1'b0);
        for (int k = 1; k < P; k++) step(1'b0, 32'h0, 1'b0, 1'b0);
        chk({nm, "_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_imm"}, 64'(out_imm), 64'(ei));
        chk({nm, "_fmt"}, 64'(out_fmt), 64'(ef));
        chk({nm, "_ill"}, 64'(out_illegal), 64'(eill));
        step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [31:0] bp_vec [4];
        logic [31:0] pend;
        logic        have;
        logic [6:0]  op;
        int          j;
        int          budget;

        rstn = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        in_tag = '0;
        out_ready = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_imm", 64'(out_imm), 64'd0);
        chk("rst_out_fmt", 64'(out_fmt), 64'(FMT_NONE));
        chk("rst_out_ill", 64'(out_illegal), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Latency: out_valid rises exactly P edges after acceptance
        step(1'b1, 32'hFFF00093, 1'b1, 1'b0);
        chk("lat_accept", 64'(acc), 64'd1);
        for (int k = 1; k <= P; k++) begin
            chk("lat_out_valid", 64'(out_valid), 64'(k == P));
            if (k < P) step(1'b0, 32'h0, 1'b1, 1'b0);
        end
        chk("addi_imm", 64'(out_imm), 64'hFFFFFFFF);
        chk("addi_fmt", 64'(out_fmt), 64'(FMT_I));
        step(1'b0, 32'h0, 1'b1, 1'b0);

        one("sw", 32'hFE112E23, 32'hFFFFFFFC, FMT_S, 1'b0);
        one("beq", 32'hFE000EE3, 32'hFFFFFFFC, FMT_B, 1'b0);
        one("lui", 32'h12345037, 32'h12345000, FMT_U, 1'b0);
        one("srai", 32'h40515093, 32'd5, FMT_SHAMT, 1'b0);
        one("bad_op", 32'hFFFFFFFF, 32'd0, FMT_NONE, 1'b1);
        one("jal_neg", 32'hFFDFF0EF, 32'hFFFFFFFC, FMT_J, 1'b0);
`ifdef IMM_GEN_CSR_ZIMM_EN
        one("csrrwi", 32'h0052D073, 32'd5, FMT_ZIMM, 1'b0);
`else
        one("csrrwi", 32'h0052D073, 32'd0, FMT_NONE, 1'b0);
`endif

        // Back-pressure: pipe of 2 fills, then in_ready must drop
        bp_vec[0] = 32'h00100093;
        bp_vec[1] = 32'hFE112E23;
        bp_vec[2] = 32'h12345037;
        bp_vec[3] = 32'h40515093;
        j = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, bp_vec[j], 1'b0, 1'b0);
            chk("bp_in_ready", 64'(acc), 64'(j < P));
            if (acc) j++;
        end
        budget = 0;
        while (j < 4 && budget < 20) begin
            step(1'b1, bp_vec[j], 1'b1, 1'b0);
            if (acc) j++;
            budget++;
        end
        chk("bp_all_accepted", 64'(j), 64'd4);
        for (int c = 0; c < P + 2; c++) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("bp_drained", 64'(q.size()), 64'd0);

        // Flush with a same-cycle offer: nothing may come out afterwards
        step(1'b1, 32'h00500113, 1'b0, 1'b0);
        step(1'b1, 32'h00700193, 1'b0, 1'b1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        for (int c = 0; c < P + 2; c++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset in mid-stream
        step(1'b1, 32'h00100093, 1'b0, 1'b0);
        step(1'b1, 32'h00200093, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_imm", 64'(out_imm), 64'd0);
        chk("arst_out_tag", 64'(out_tag), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        stall_pending = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        // Random traffic; an offer is held until accepted or flushed
        have = 1'b0;
        pend = '0;
        for (int c = 0; c < 800; c++) begin
            logic v;
            logic ordy;
            logic fl;
            if (!have) begin
                op   = OPS[$urandom_range(0, 13)];
                pend = {$urandom} & 32'hFFFFFF80;
                pend = pend | {25'b0, op};
            end
            v    = have || ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 39) == 0);
            if (fl) ordy = 1'b0;
            step(v, pend, ordy, fl);
            have = v && !acc && !fl;
        end

        budget = 0;
        while (q.size() != 0 && budget < 20) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            budget++;
        end
        chk("final_queue_empty", 64'(q.size()), 64'd0);
        chk("final_out_valid", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage of the RV32I/RV64I core. It decodes the immediate format directly from the raw instruction word (no external EXTOp), sign/zero-extends it to XLEN, and delivers it through PIPE_STAGES valid/ready register slices with stall back-pressure, flush and a sideband tag. Sits between fetch/IF-ID and the ID-EX register; ALU operand muxing consumes out_imm and out_fmt.

## Interface
- XLEN, 32: output immediate width; 32 or 64 only.
- PIPE_STAGES, 1: register slices, 1 or 2; 0 is illegal.
- TAG_W, 32: width of sideband tag carried alongside (typically PC).
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of every in-flight entry.
- in_valid  in  1  instruction offered.
- in_ready  out  1  block accepts this cycle.
- in_instr  in  32  raw instruction word.
- in_tag  in  TAG_W  sideband, passed through unmodified.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  format code (package enum).
- out_illegal  out  1  opcode not recognised.
- out_tag  out  TAG_W  tag matching out_imm.

## Operation
- Format from opcode [6:0]: 0010011 OP-IMM → I, except funct3 001/101 → SHAMT; 0000011 LOAD, 1100111 JALR → I; 0100011 → S; 1100011 → B; 0110111/0010111 → U; 1101111 → J; 0110011 → NONE; 1110011 SYSTEM → NONE (ZIMM when macro enabled, funct3[2]=1); 0011011 (XLEN=64 only) → I, SHAMT for funct3 001/101; anything else → NONE with illegal=1.
- Extension: I {sext instr[31:20]}; S {sext instr[31:25],instr[11:7]}; B {sext instr[31],instr[7],instr[30:25],instr[11:8],0}; U {sext instr[31:12],12'b0} (sign-extended above bit 31 when XLEN=64); J {sext instr[31],instr[19:12],instr[20],instr[30:21],0}; SHAMT zero-extended instr[24:20] (instr[25:20] for XLEN=64 opcode 0010011); NONE → 0.
- Decode/extension is combinational on the input side; stage 0 registers {imm, fmt, illegal, tag}; later stages copy.
- Per stage k: ready_k = !valid_k | ready_{k+1}; ready_{PIPE_STAGES} = out_ready; in_ready = ready_0. Combinational out_ready→in_ready path is permitted.
- Stage loads when its upstream is valid and ready_k; valid_k clears when downstream takes it and nothing new arrives.
- flush: all valid bits 0 next edge; takes priority over a same-cycle in_valid (instruction dropped) and over out_ready.

## Timing
- Reset: all valid=0, all data registers 0 → out_valid=0, out_imm=0, out_fmt=NONE, out_illegal=0, out_tag=0; in_ready=1 during/after reset.
- Reset asserted mid-stream clears outputs immediately (asynchronous), no handshake completes.
- Latency PIPE_STAGES cycles from accepted input to out_valid; throughput 1/cycle when out_ready=1.
- Full pipeline with out_ready=0: in_ready=0; data held stable, order preserved, no loss or duplication.
- out_* stable while out_valid=1 & out_ready=0.

## Configuration
- IMM_GEN_CSR_ZIMM_EN defined: SYSTEM with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) → fmt ZIMM, out_imm = zero-extended instr[19:15].
- Undefined: those encodings → NONE, imm 0, illegal=0; ZIMM enum value is never produced.

## Structure
- Package imm_gen_pkg: 3-bit format enum (NONE, I, SHAMT, S, B, U, J, ZIMM), opcode constants, XLEN legality check.
- One sub-module imm_gen_slice: a single valid/ready register slice parametrised by payload width, instantiated PIPE_STAGES times via generate.

## Test plan
- addi x1,x0,-1, 0xFFF00093, XLEN=32 → one cycle later out_imm=0xFFFFFFFF, fmt I.
- sw x1,-4(x2) 0xFE112E23 → 0xFFFFFFFC fmt S; beq x0,x0,-4 0xFE000EE3 → 0xFFFFFFFC fmt B; lui 0x12345037 → 0x12345000 fmt U (XLEN=64: 0x0000000012345000).
- srai x1,x2,5 0x40515093 → out_imm=5, fmt SHAMT; opcode 0x7F → illegal=1, imm 0.
- PIPE_STAGES=2, four back-to-back instructions, out_ready low 3 cycles → in_ready drops after 2 accepted; all four emerge in order, none lost.
- flush with in_valid=1 same cycle → out_valid=0 next cycle, that instruction never appears; rstn pulsed mid-stream → out_valid=0 immediately.
- csrrwi 0x0052D073 → with IMM_GEN_CSR_ZIMM_EN out_imm=5 fmt ZIMM; without, imm 0 fmt NONE.
